// File: rtl/io_irq_pkg.sv
// io_irq_pkg: shared constants for the I/O-port interrupt controller.
//   OFS_*      register offsets from BASE_PORT
//   irq_state_t interrupt-request FSM encoding
//   ID_NONE    value read from ID when nothing is pending and unmasked
package io_irq_pkg;

  localparam logic [7:0] OFS_MASK = 8'd0;
  localparam logic [7:0] OFS_PEND = 8'd1;
  localparam logic [7:0] OFS_CTRL = 8'd2;
  localparam logic [7:0] OFS_SWI  = 8'd3;
  localparam logic [7:0] OFS_ID   = 8'd4;
  localparam logic [7:0] NUM_REGS = 8'd5;

  localparam logic [7:0] ID_NONE  = 8'h80;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    HOLD   = 2'd2
  } irq_state_t;

endpackage

// File: rtl/irq_sync_edge.sv
// irq_sync_edge: two-flop synchronizer followed by a history flop, producing
// a one-cycle pulse on each rising edge of an asynchronous input.
//   clk        system clock
//   rst        synchronous active-high reset
//   async_in   asynchronous level input
//   edge_pulse high for one cycle after a synchronized rising edge
module irq_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic edge_pulse
);

  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= async_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // prev clears on reset, so a source held high through reset yields one edge
  assign edge_pulse = sync2 & ~prev;

endmodule

// File: rtl/io_irq_ctrl.sv
// io_irq_ctrl: memory-mapped interrupt controller on the CPU I/O port bus.
// Synchronizes and edge-detects peripheral sources into a pending register,
// masks them, and drives a registered interrupt request with a holdoff gap.
//   clk, rst   system clock, synchronous active-high reset
//   irq_src    asynchronous rising-edge interrupt sources
//   port_id    I/O address; out_port write data; io_strb write strobe
//   rd_data    combinational read data for the in_port mux
//   rd_hit     port_id falls inside BASE_PORT..BASE_PORT+4
//   interrupt  registered request to the CPU
//
// state  | meaning
// IDLE   | no request; interrupt low
// ASSERT | request presented to the CPU; interrupt high
// HOLD   | forced low gap after deassertion; hold_cnt counts down to 0
module io_irq_ctrl
  import io_irq_pkg::*;
#(
  parameter int          NUM_SRC   = 8,
  parameter logic [7:0]  BASE_PORT = 8'hF0,
  parameter int          HOLDOFF   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [7:0]         port_id,
  input  logic [7:0]         out_port,
  input  logic               io_strb,
  output logic [7:0]         rd_data,
  output logic               rd_hit,
  output logic               interrupt
);

  logic [7:0]         ofs;
  logic               wr_en;
  logic [NUM_SRC-1:0] hw_edge;
  logic [NUM_SRC-1:0] mask_q;
  logic [NUM_SRC-1:0] pend_q;
  logic               en_q;
  logic [NUM_SRC-1:0] pend_set;
  logic [NUM_SRC-1:0] pend_clr;
  logic [NUM_SRC-1:0] active;
  logic               req;
  logic [7:0]         id_val;
  logic [3:0]         hold_cnt;
  irq_state_t         state;

  // Unsigned wrap makes addresses below BASE_PORT land far out of range
  assign ofs    = port_id - BASE_PORT;
  assign rd_hit = (ofs < NUM_REGS);
  assign wr_en  = io_strb & rd_hit;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    irq_sync_edge u_sync_edge (
      .clk        (clk),
      .rst        (rst),
      .async_in   (irq_src[i]),
      .edge_pulse (hw_edge[i])
    );
  end

  always_comb begin
    pend_set = hw_edge;
    pend_clr = '0;
    if (wr_en && ofs == OFS_SWI)  pend_set = pend_set | out_port[NUM_SRC-1:0];
    if (wr_en && ofs == OFS_PEND) pend_clr = out_port[NUM_SRC-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q <= '0;
      pend_q <= '0;
      en_q   <= 1'b0;
    end else begin
      if (wr_en && ofs == OFS_MASK) mask_q <= out_port[NUM_SRC-1:0];
      if (wr_en && ofs == OFS_CTRL) en_q   <= out_port[0];
      // set applied after clear so a coincident event is never dropped
      pend_q <= (pend_q & ~pend_clr) | pend_set;
    end
  end

  assign active = pend_q & mask_q;
  assign req    = en_q & (|active);

  always_comb begin
    id_val = ID_NONE;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) id_val = {5'b0, 3'(i)};
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_hit) begin
      case (ofs)
        OFS_MASK: rd_data = 8'(mask_q);
        OFS_PEND: rd_data = 8'(pend_q);
        OFS_CTRL: rd_data = {7'b0, en_q};
        OFS_ID:   rd_data = id_val;
        default:  rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      interrupt <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state     <= ASSERT;
            interrupt <= 1'b1;
          end
        end
        ASSERT: begin
          if (!req) begin
            state     <= HOLD;
            interrupt <= 1'b0;
            hold_cnt  <= 4'(HOLDOFF - 1);
          end
        end
        HOLD: begin
          if (hold_cnt == '0) begin
            if (req) begin
              state     <= ASSERT;
              interrupt <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            hold_cnt <= hold_cnt - 4'd1;
          end
        end
        default: begin
          state     <= IDLE;
          interrupt <= 1'b0;
        end
      endcase
    end
  end

endmodule
